// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares one single-port synchronous data memory between the core's
//   memory-stage load/store port and a debug/loader port. Single-beat accesses
//   are arbitrated round-robin with a zero-cycle grant. Read data comes back one
//   cycle later, steered to whichever port owned the read. A debug halt mode
//   freezes the core and hands the memory exclusively to the debug port.
//
// Ports:
//   CLK, RST             clock, asynchronous active-high reset
//   Core_* (in)          core request bundle: Req, W_En, Addr, W_Data, Byte_En
//   Core_Gnt             core access accepted this cycle
//   Core_R_Valid/R_Data  read return to core, one cycle after a granted read
//   Stall_Core           core must hold its request (lost arbitration / halted)
//   Dbg_* (in)           debug request bundle, same meaning as the core bundle
//   Dbg_Gnt              debug access accepted this cycle
//   Dbg_R_Valid/R_Data   read return to debug port
//   Dbg_Halt_Req         level request for exclusive debug ownership
//   Core_Halted          exclusive debug ownership is in effect
//   MEM_En/W_En/Addr/W_Data  memory strobe, byte write enables, address, data
//   MEM_R_Data           memory read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Core_Req,
    input  logic                Core_W_En,
    input  logic [ADDR_W-1:0]   Core_Addr,
    input  logic [DATA_W-1:0]   Core_W_Data,
    input  logic [DATA_W/8-1:0] Core_Byte_En,
    output logic                Core_Gnt,
    output logic                Core_R_Valid,
    output logic [DATA_W-1:0]   Core_R_Data,
    output logic                Stall_Core,
    input  logic                Dbg_Req,
    input  logic                Dbg_W_En,
    input  logic [ADDR_W-1:0]   Dbg_Addr,
    input  logic [DATA_W-1:0]   Dbg_W_Data,
    input  logic [DATA_W/8-1:0] Dbg_Byte_En,
    output logic                Dbg_Gnt,
    output logic                Dbg_R_Valid,
    output logic [DATA_W-1:0]   Dbg_R_Data,
    input  logic                Dbg_Halt_Req,
    output logic                Core_Halted,
    output logic                MEM_En,
    output logic [DATA_W/8-1:0] MEM_W_En,
    output logic [ADDR_W-1:0]   MEM_Addr,
    output logic [DATA_W-1:0]   MEM_W_Data,
    input  logic [DATA_W-1:0]   MEM_R_Data
);

    typedef enum logic [1:0] {
        ST_SHARED,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    typedef enum logic {
        OWN_CORE,
        OWN_DBG
    } owner_t;

    state_t r_state;
    owner_t r_lastGnt;
    logic   r_coreRValid;
    logic   r_dbgRValid;
    logic   r_coreHalted;

    logic   w_coreGnt;
    logic   w_dbgGnt;

    // Grant decision. In SHARED a lone requester always wins; on contention
    // the port that did not win last time gets the memory, which alternates
    // grants under continuous contention. DRAIN grants nobody so the last
    // SHARED read can return cleanly. HALTED serves only the debug port.
    always_comb begin
        w_coreGnt = 1'b0;
        w_dbgGnt  = 1'b0;
        case (r_state)
            ST_SHARED: begin
                if (Core_Req && Dbg_Req) begin
                    if (r_lastGnt == OWN_DBG) begin
                        w_coreGnt = 1'b1;
                    end else begin
                        w_dbgGnt = 1'b1;
                    end
                end else begin
                    w_coreGnt = Core_Req;
                    w_dbgGnt  = Dbg_Req;
                end
            end
            ST_HALTED: begin
                w_dbgGnt = Dbg_Req;
            end
            default: begin
            end
        endcase
    end

    // Memory drive. The winner's request bundle goes to the memory. With no
    // grant every memory output is forced to zero, so the RAM never sees a
    // stray write enable or address.
    always_comb begin
        MEM_En     = w_coreGnt | w_dbgGnt;
        MEM_W_En   = '0;
        MEM_Addr   = '0;
        MEM_W_Data = '0;
        if (w_coreGnt) begin
            MEM_W_En   = Core_W_En ? Core_Byte_En : '0;
            MEM_Addr   = Core_Addr;
            MEM_W_Data = Core_W_Data;
        end else if (w_dbgGnt) begin
            MEM_W_En   = Dbg_W_En ? Dbg_Byte_En : '0;
            MEM_Addr   = Dbg_Addr;
            MEM_W_Data = Dbg_W_Data;
        end
    end

    // Registered state: FSM, round-robin history, read ownership for the
    // one-cycle return, and the halted flag. Leaving HALTED records the debug
    // port as last winner, so the core wins the first contention after a halt.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ST_SHARED;
            r_lastGnt    <= OWN_DBG;
            r_coreRValid <= 1'b0;
            r_dbgRValid  <= 1'b0;
            r_coreHalted <= 1'b0;
        end else begin
            r_coreRValid <= w_coreGnt & ~Core_W_En;
            r_dbgRValid  <= w_dbgGnt & ~Dbg_W_En;

            if (w_coreGnt) begin
                r_lastGnt <= OWN_CORE;
            end else if (w_dbgGnt) begin
                r_lastGnt <= OWN_DBG;
            end

            case (r_state)
                ST_SHARED: begin
                    if (Dbg_Halt_Req) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state      <= ST_HALTED;
                    r_coreHalted <= 1'b1;
                end
                ST_HALTED: begin
                    if (!Dbg_Halt_Req) begin
                        r_state      <= ST_SHARED;
                        r_coreHalted <= 1'b0;
                        r_lastGnt    <= OWN_DBG;
                    end
                end
                default: begin
                    r_state <= ST_SHARED;
                end
            endcase
        end
    end

    // Read data is steered to the owning port only; the other port sees zero.
    assign Core_Gnt     = w_coreGnt;
    assign Dbg_Gnt      = w_dbgGnt;
    assign Stall_Core   = Core_Req & ~w_coreGnt;
    assign Core_R_Valid = r_coreRValid;
    assign Dbg_R_Valid  = r_dbgRValid;
    assign Core_R_Data  = r_coreRValid ? MEM_R_Data : '0;
    assign Dbg_R_Data   = r_dbgRValid ? MEM_R_Data : '0;
    assign Core_Halted  = r_coreHalted;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives directed and randomized traffic into dmem_arbiter, plays the part of
// the synchronous RAM, and compares every observable output against a
// transaction-level reference model (winner selection, halt phase, pending
// read, shadow memory contents).
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MODE_SHARED = 0;
    localparam int MODE_DRAIN  = 1;
    localparam int MODE_HALTED = 2;
    localparam int NONE = -1;
    localparam int CORE = 0;
    localparam int DBG  = 1;

    logic        CLK;
    logic        RST;
    logic        Core_Req, Core_W_En, Core_Gnt, Core_R_Valid, Stall_Core;
    logic [9:0]  Core_Addr;
    logic [31:0] Core_W_Data, Core_R_Data;
    logic [3:0]  Core_Byte_En;
    logic        Dbg_Req, Dbg_W_En, Dbg_Gnt, Dbg_R_Valid;
    logic [9:0]  Dbg_Addr;
    logic [31:0] Dbg_W_Data, Dbg_R_Data;
    logic [3:0]  Dbg_Byte_En;
    logic        Dbg_Halt_Req, Core_Halted;
    logic        MEM_En;
    logic [3:0]  MEM_W_En;
    logic [9:0]  MEM_Addr;
    logic [31:0] MEM_W_Data, MEM_R_Data;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .Core_Req(Core_Req), .Core_W_En(Core_W_En), .Core_Addr(Core_Addr),
        .Core_W_Data(Core_W_Data), .Core_Byte_En(Core_Byte_En),
        .Core_Gnt(Core_Gnt), .Core_R_Valid(Core_R_Valid), .Core_R_Data(Core_R_Data),
        .Stall_Core(Stall_Core),
        .Dbg_Req(Dbg_Req), .Dbg_W_En(Dbg_W_En), .Dbg_Addr(Dbg_Addr),
        .Dbg_W_Data(Dbg_W_Data), .Dbg_Byte_En(Dbg_Byte_En),
        .Dbg_Gnt(Dbg_Gnt), .Dbg_R_Valid(Dbg_R_Valid), .Dbg_R_Data(Dbg_R_Data),
        .Dbg_Halt_Req(Dbg_Halt_Req), .Core_Halted(Core_Halted),
        .MEM_En(MEM_En), .MEM_W_En(MEM_W_En), .MEM_Addr(MEM_Addr),
        .MEM_W_Data(MEM_W_Data), .MEM_R_Data(MEM_R_Data)
    );

    // Free-running clock, 10 time units per cycle.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          assertCount;
    int          failCount;

    // Reference model state.
    int          mMode;
    int          mLast;
    int          mPendOwner;
    logic [31:0] mPendData;
    int          eWinner;
    bit          prevStall;
    logic [31:0] refMem [1024];

    // RAM stand-in state plus the memory-side request sampled mid-cycle.
    logic [31:0] tbMem [1024];
    logic        sEn;
    logic [3:0]  sWe;
    logic [9:0]  sAddr;
    logic [31:0] sWd;

    // Every comparison funnels through here so counting and reporting stay
    // in one place.
    task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle's worth of request inputs on both ports plus halt.
    task applyStimulus(input logic cReq, input logic cWe, input logic [9:0] cAddr,
                       input logic [31:0] cWd, input logic [3:0] cBe,
                       input logic dReq, input logic dWe, input logic [9:0] dAddr,
                       input logic [31:0] dWd, input logic [3:0] dBe, input logic halt);
        Core_Req = cReq; Core_W_En = cWe; Core_Addr = cAddr;
        Core_W_Data = cWd; Core_Byte_En = cBe;
        Dbg_Req = dReq; Dbg_W_En = dWe; Dbg_Addr = dAddr;
        Dbg_W_Data = dWd; Dbg_Byte_En = dBe;
        Dbg_Halt_Req = halt;
    endtask

    // Mid-cycle: decide who should win from the arbitration rules, then
    // compare every output against the model's view of this cycle.
    task checkCycle();
        logic        eEn;
        logic [3:0]  eWe;
        logic [9:0]  eAddr;
        logic [31:0] eWd;
        @(negedge CLK);
        eWinner = NONE;
        if (mMode == MODE_SHARED) begin
            if (Core_Req && Dbg_Req) eWinner = (mLast == DBG) ? CORE : DBG;
            else if (Core_Req)       eWinner = CORE;
            else if (Dbg_Req)        eWinner = DBG;
        end else if (mMode == MODE_HALTED && Dbg_Req) begin
            eWinner = DBG;
        end
        eEn = 1'b0; eWe = 4'h0; eAddr = 10'h0; eWd = 32'h0;
        if (eWinner == CORE) begin
            eEn = 1'b1; eAddr = Core_Addr; eWd = Core_W_Data;
            eWe = Core_W_En ? Core_Byte_En : 4'h0;
        end else if (eWinner == DBG) begin
            eEn = 1'b1; eAddr = Dbg_Addr; eWd = Dbg_W_Data;
            eWe = Dbg_W_En ? Dbg_Byte_En : 4'h0;
        end
        checkOutput("core_gnt", Core_Gnt, eWinner == CORE);
        checkOutput("dbg_gnt", Dbg_Gnt, eWinner == DBG);
        checkOutput("stall_core", Stall_Core, Core_Req && eWinner != CORE);
        checkOutput("mem_en", MEM_En, eEn);
        checkOutput("mem_w_en", MEM_W_En, eWe);
        checkOutput("mem_addr", MEM_Addr, eAddr);
        checkOutput("mem_w_data", MEM_W_Data, eWd);
        checkOutput("core_r_valid", Core_R_Valid, mPendOwner == CORE);
        checkOutput("dbg_r_valid", Dbg_R_Valid, mPendOwner == DBG);
        checkOutput("core_r_data", Core_R_Data, (mPendOwner == CORE) ? mPendData : 32'h0);
        checkOutput("dbg_r_data", Dbg_R_Data, (mPendOwner == DBG) ? mPendData : 32'h0);
        checkOutput("core_halted", Core_Halted, mMode == MODE_HALTED);
        sEn = MEM_En; sWe = MEM_W_En; sAddr = MEM_Addr; sWd = MEM_W_Data;
        prevStall = Core_Req && eWinner != CORE;
    endtask

    // Clock edge: the RAM stand-in acts on what the DUT presented, and the
    // reference model advances on what the rules say should have happened.
    task advance();
        bit          readNow;
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        we;
        @(posedge CLK);
        readNow = 1'b0;
        if (sEn) begin
            if (sWe == 4'h0) begin
                MEM_R_Data = tbMem[sAddr];
                readNow = 1'b1;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sWe[b]) tbMem[sAddr][8*b +: 8] = sWd[8*b +: 8];
            end
        end
        if (!readNow) MEM_R_Data = $urandom;

        mPendOwner = NONE;
        if (eWinner != NONE) begin
            a  = (eWinner == CORE) ? Core_Addr : Dbg_Addr;
            d  = (eWinner == CORE) ? Core_W_Data : Dbg_W_Data;
            be = (eWinner == CORE) ? Core_Byte_En : Dbg_Byte_En;
            we = (eWinner == CORE) ? Core_W_En : Dbg_W_En;
            mLast = eWinner;
            if (!we) begin
                mPendOwner = eWinner;
                mPendData  = refMem[a];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) refMem[a][8*b +: 8] = d[8*b +: 8];
            end
        end
        case (mMode)
            MODE_SHARED: if (Dbg_Halt_Req) mMode = MODE_DRAIN;
            MODE_DRAIN:  mMode = MODE_HALTED;
            default: if (!Dbg_Halt_Req) begin mMode = MODE_SHARED; mLast = DBG; end
        endcase
        #1;
    endtask

    // Asynchronous reset pulse raised away from any clock edge; the return
    // path must clear immediately, before any clock edge arrives.
    task doReset();
        #1 RST = 1'b1;
        #1;
        checkOutput("rst_core_r_valid", Core_R_Valid, 1'b0);
        checkOutput("rst_dbg_r_valid", Dbg_R_Valid, 1'b0);
        checkOutput("rst_core_halted", Core_Halted, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        MEM_R_Data = $urandom;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        mMode = MODE_SHARED; mLast = DBG; mPendOwner = NONE; prevStall = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic        halt;
        assertCount = 0;
        failCount   = 0;
        RST = 1'b1;
        MEM_R_Data = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            tbMem[i]  = $urandom;
            refMem[i] = tbMem[i];
        end
        tbMem[10'h010]  = 32'hDEADBEEF;
        refMem[10'h010] = 32'hDEADBEEF;
        doReset();

        // Core-only read with a known memory word.
        applyStimulus(1, 0, 10'h010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0);
        checkCycle();
        checkOutput("t1_core_gnt", Core_Gnt, 1'b1);
        checkOutput("t1_mem_en", MEM_En, 1'b1);
        checkOutput("t1_mem_w_en", MEM_W_En, 4'h0);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkCycle();
        checkOutput("t1_core_r_valid", Core_R_Valid, 1'b1);
        checkOutput("t1_core_r_data", Core_R_Data, 32'hDEADBEEF);
        checkOutput("t1_dbg_r_valid", Dbg_R_Valid, 1'b0);
        advance();

        // Core partial write at the top address.
        applyStimulus(1, 1, 10'h3FF, 32'h12345678, 4'b0011, 0, 0, 0, 0, 0, 0);
        checkCycle();
        checkOutput("t3_mem_w_en", MEM_W_En, 4'b0011);
        checkOutput("t3_mem_addr", MEM_Addr, 10'h3FF);
        checkOutput("t3_mem_w_data", MEM_W_Data, 32'h12345678);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkCycle();
        checkOutput("t3_core_r_valid", Core_R_Valid, 1'b0);
        advance();

        // Continuous contention straight out of reset alternates grants.
        doReset();
        applyStimulus(1, 0, 10'h001, 0, 0, 1, 0, 10'h002, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checkCycle();
            checkOutput("t2_core_gnt", Core_Gnt, (i % 2) == 0);
            checkOutput("t2_stall", Stall_Core, (i % 2) == 1);
            advance();
        end

        // Halt raised alongside a granted core read, then drain and halt.
        doReset();
        applyStimulus(1, 0, 10'h020, 0, 0, 0, 0, 0, 0, 0, 1);
        checkCycle();
        checkOutput("t4_core_gnt", Core_Gnt, 1'b1);
        advance();
        applyStimulus(1, 0, 10'h021, 0, 0, 1, 0, 10'h030, 0, 0, 1);
        checkCycle();
        checkOutput("t4_drain_r_valid", Core_R_Valid, 1'b1);
        checkOutput("t4_drain_core_gnt", Core_Gnt, 1'b0);
        checkOutput("t4_drain_dbg_gnt", Dbg_Gnt, 1'b0);
        advance();
        checkCycle();
        checkOutput("t4_halted", Core_Halted, 1'b1);
        checkOutput("t4_stall", Stall_Core, 1'b1);
        checkOutput("t4_dbg_gnt", Dbg_Gnt, 1'b1);
        advance();

        // Drop halt with both requesting; core wins first contention after.
        applyStimulus(1, 0, 10'h021, 0, 0, 1, 0, 10'h031, 0, 0, 0);
        checkCycle();
        checkOutput("t5_last_halted_dbg_gnt", Dbg_Gnt, 1'b1);
        advance();
        checkCycle();
        checkOutput("t5_core_gnt", Core_Gnt, 1'b1);
        checkOutput("t5_core_halted", Core_Halted, 1'b0);
        advance();

        // Reset lands while a debug read return is pending.
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 10'h040, 0, 0, 0);
        checkCycle();
        advance();
        doReset();
        applyStimulus(1, 0, 10'h041, 0, 0, 1, 0, 10'h042, 0, 0, 0);
        checkCycle();
        checkOutput("t6_core_gnt", Core_Gnt, 1'b1);
        advance();

        // Randomized traffic; a stalled core keeps its request stable.
        halt = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            if (!prevStall) begin
                Core_Req     = ($urandom_range(0, 9) < 6);
                Core_W_En    = $urandom_range(0, 1);
                Core_Addr    = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
                Core_W_Data  = $urandom;
                Core_Byte_En = 4'($urandom_range(0, 15));
            end
            Dbg_Req      = ($urandom_range(0, 9) < 6);
            Dbg_W_En     = $urandom_range(0, 1);
            Dbg_Addr     = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
            Dbg_W_Data   = $urandom;
            Dbg_Byte_En  = 4'($urandom_range(0, 15));
            Dbg_Halt_Req = halt;
            checkCycle();
            advance();
            if ($urandom_range(0, 199) == 0) begin
                doReset();
                halt = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
